yarp_data_mem_responder: RTL

- Memory-side responder for the core's load/store request interface, driven by control fields data_req, data_wr and data_byte (BYTE/HALF_WORD/WORD encoding).
- Holds a word-organised data RAM and accepts one request at a time.
- Returns a response after a parameterised latency, with byte-lane writes and right-aligned read data.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/yarp_data_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/yarp_data_mem_responder.sv
// Load/store responder for the core data interface: word-organised byte-lane RAM,
// fixed-latency single-outstanding response with alignment/range/size error flagging.

module yarp_dmem_lane #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [7:0]                     wdata,
  output logic [7:0]                     rdata
);
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  // Asynchronous read so a load can be captured on the same edge it is accepted.
  assign rdata = mem[idx];
endmodule

module yarp_data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rd_data_o,
  output logic        data_err_o
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int CW        = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        err;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q;
  rsp_t    rsp_q, rsp_d;
  req_t    req;
  logic    accept;

  logic [31:0]                   off;
  logic [AW-1:0]                 idx;
  logic                          size_err, align_err, range_err, err;
  logic [NUM_LANES-1:0]          lane_sel, lane_we;
  logic [NUM_LANES-1:0][7:0]     lane_wdata, lane_rdata;
  logic [31:0]                   rd_word, ld_data;

  assign req = '{addr: data_addr_i, size: data_byte_i, wr: data_wr_i, wdata: data_wr_data_i};

  // BASE_ADDR is aligned to the region size, so off[1:0] equals addr[1:0].
  assign off = req.addr - BASE_ADDR;
  assign idx = off[AW+1:2];

  assign size_err  = (req.size == 2'b10);
  assign align_err = ((req.size == SZ_HALF) && off[0]) ||
                     ((req.size == SZ_WORD) && (off[1:0] != 2'b00));
  assign range_err = |off[31:AW+2];
  assign err       = size_err || align_err || range_err;

  // Lane selection and store data replicated so each lane sees its own slice.
  always_comb begin
    lane_sel   = '0;
    lane_wdata = req.wdata;
    case (req.size)
      SZ_BYTE: begin
        lane_sel[off[1:0]] = 1'b1;
        lane_wdata         = {NUM_LANES{req.wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_sel   = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req.wdata[15:0]}};
      end
      SZ_WORD: lane_sel = '1;
      default: lane_sel = '0;
    endcase
  end

  assign lane_we = {NUM_LANES{accept && req.wr && !err}} & lane_sel;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    yarp_dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (idx),
      .wdata (lane_wdata[l]),
      .rdata (lane_rdata[l])
    );
  end

  assign rd_word = lane_rdata;

  always_comb begin
    ld_data = rd_word;
    case (req.size)
      SZ_BYTE: ld_data = {24'b0, lane_rdata[off[1:0]]};
      SZ_HALF: ld_data = off[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    rsp_d.err     = err;
    rsp_d.rd_data = (req.wr || err) ? 32'b0 : ld_data;
  end

  // State register, latency counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_q <= rsp_d;
        cnt_q <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_req_i) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    case (state_q)
      IDLE:    data_gnt_o    = data_req_i;
      RESP:    data_rvalid_o = 1'b1;
      default: ;
    endcase
  end

  assign accept         = data_gnt_o;
  assign data_rd_data_o = rsp_q.rd_data;
  assign data_err_o     = rsp_q.err;
endmodule
